// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/MEM cache-port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INST_BUSY = 2'd1,
        DATA_BUSY = 2'd2
    } arb_state_e;

    localparam logic REQ_INST = 1'b0;
    localparam logic REQ_DATA = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and cache-side signals of the shared memory port.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              inst_call_begin;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_return_ready;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_call_begin;
    logic              data_wr;
    logic [3:0]        data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_return_ready;
    logic [DATA_W-1:0] data_rdata;

    logic              mem_call_begin;
    logic              mem_wr;
    logic [3:0]        mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_return_ready;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              proto_err;

    // Arbiter view.
    modport slave (
        input  inst_call_begin, inst_addr,
        input  data_call_begin, data_wr, data_wstrb, data_addr, data_wdata,
        input  mem_return_ready, mem_rdata,
        output inst_return_ready, inst_rdata,
        output data_return_ready, data_rdata,
        output mem_call_begin, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        output busy, proto_err
    );

    // Pipeline/cache view.
    modport master (
        output inst_call_begin, inst_addr,
        output data_call_begin, data_wr, data_wstrb, data_addr, data_wdata,
        output mem_return_ready, mem_rdata,
        input  inst_return_ready, inst_rdata,
        input  data_return_ready, data_rdata,
        input  mem_call_begin, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        input  busy, proto_err
    );
endinterface

// File: rtl/arb_req_slot.sv
// One-deep pending request register for a single requester.
module arb_req_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         call,
    input  logic [W-1:0] pld_in,
    input  logic         inflight,
    input  logic         take,
    output logic         cand,
    output logic [W-1:0] cand_pld,
    output logic         err
);
    logic         valid_q, valid_d;
    logic [W-1:0] pld_q, pld_d;
    logic         accept;

    always_comb begin
        // A pulse is only legal when nothing of this requester is outstanding.
        accept   = call && !valid_q && !inflight;
        err      = call && !accept;
        cand     = valid_q || accept;
        cand_pld = valid_q ? pld_q : pld_in;
        valid_d  = valid_q;
        pld_d    = pld_q;
        if (take) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            pld_d   = pld_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pld_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pld_q   <= pld_d;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one cache port between fetch and load/store, alternating on conflicts.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    localparam int DPW = 1 + 4 + ADDR_W + DATA_W;

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic              mem_call_q, mem_call_d;
    logic              wr_q, wr_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              perr_q, perr_d;

    logic              i_cand, d_cand, i_err, d_err, i_take, d_take;
    logic [ADDR_W-1:0] i_pld;
    logic [DPW-1:0]    d_pld;
    logic              arb_en, grant_v, grant_id;

    arb_req_slot #(.W(ADDR_W)) u_inst_slot (
        .clk      (clk),
        .rst_n    (reset),
        .call     (bus.inst_call_begin),
        .pld_in   (bus.inst_addr),
        .inflight (state_q == INST_BUSY),
        .take     (i_take),
        .cand     (i_cand),
        .cand_pld (i_pld),
        .err      (i_err)
    );

    arb_req_slot #(.W(DPW)) u_data_slot (
        .clk      (clk),
        .rst_n    (reset),
        .call     (bus.data_call_begin),
        .pld_in   ({bus.data_wr, bus.data_wstrb, bus.data_addr, bus.data_wdata}),
        .inflight (state_q == DATA_BUSY),
        .take     (d_take),
        .cand     (d_cand),
        .cand_pld (d_pld),
        .err      (d_err)
    );

    always_comb begin
        // The in-flight owner cannot be a candidate, so a completion edge is free to regrant.
        arb_en  = (state_q == IDLE) || bus.mem_return_ready;
        grant_v = arb_en && (i_cand || d_cand);
        if (i_cand && d_cand) grant_id = (last_q == REQ_INST) ? REQ_DATA : REQ_INST;
        else                  grant_id = d_cand ? REQ_DATA : REQ_INST;
        i_take = grant_v && (grant_id == REQ_INST);
        d_take = grant_v && (grant_id == REQ_DATA);

        state_d    = state_q;
        last_d     = last_q;
        mem_call_d = 1'b0;
        wr_d       = wr_q;
        wstrb_d    = wstrb_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if (arb_en) state_d = IDLE;
        if (grant_v) begin
            last_d     = grant_id;
            mem_call_d = 1'b1;
            if (grant_id == REQ_DATA) begin
                state_d                          = DATA_BUSY;
                {wr_d, wstrb_d, addr_d, wdata_d} = d_pld;
            end else begin
                state_d = INST_BUSY;
                wr_d    = 1'b0;
                wstrb_d = 4'b0000;
                addr_d  = i_pld;
                wdata_d = '0;
            end
        end

        perr_d = perr_q || i_err || d_err || (bus.mem_return_ready && (state_q == IDLE));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            last_q     <= REQ_INST;
            mem_call_q <= 1'b0;
            wr_q       <= 1'b0;
            wstrb_q    <= 4'b0000;
            addr_q     <= '0;
            wdata_q    <= '0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            mem_call_q <= mem_call_d;
            wr_q       <= wr_d;
            wstrb_q    <= wstrb_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            perr_q     <= perr_d;
        end
    end

    assign bus.mem_call_begin = mem_call_q;
    assign bus.mem_wr         = wr_q;
    assign bus.mem_wstrb      = wstrb_q;
    assign bus.mem_addr       = addr_q;
    assign bus.mem_wdata      = wdata_q;
    assign bus.busy           = (state_q != IDLE);
    assign bus.proto_err      = perr_q;

    // Zero-latency return demux; the non-owner sees all zeros.
    assign bus.inst_return_ready = bus.mem_return_ready && (state_q == INST_BUSY);
    assign bus.inst_rdata        = bus.inst_return_ready ? bus.mem_rdata : '0;
    assign bus.data_return_ready = bus.mem_return_ready && (state_q == DATA_BUSY);
    assign bus.data_rdata        = bus.data_return_ready ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed table plus hand sequences for the cache-port arbiter.
module tb_mem_port_arbiter;
    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;
    localparam logic [31:0] Z32 = 32'h0;
    localparam logic [3:0]  Z4  = 4'h0;

    typedef struct {
        logic rst; logic ic; logic [31:0] ia;
        logic dc; logic dwr; logic [3:0] ds; logic [31:0] da; logic [31:0] dd;
        logic mrr; logic [31:0] mrd;
        logic e_mc; logic [31:0] e_ma; logic e_busy;
        logic e_irr; logic [31:0] e_ird; logic e_drr; logic [31:0] e_drd; logic e_perr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   row = 0;
    int   drr_cnt;
    vec_t tbl[23];

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d act=%h exp=%h", nm, row, act, exp);
        end
    endtask

    task automatic clr_in();
        bus.inst_call_begin  = 1'b0; bus.inst_addr  = '0;
        bus.data_call_begin  = 1'b0; bus.data_wr    = 1'b0; bus.data_wstrb = '0;
        bus.data_addr        = '0;   bus.data_wdata = '0;
        bus.mem_return_ready = 1'b0; bus.mem_rdata  = '0;
    endtask

    // New cycle: inputs change on the falling edge, checks follow #1 later.
    task automatic nrow();
        @(negedge clk);
        row++;
        rst_n = 1'b1;
        clr_in();
    endtask

    task automatic do_reset();
        nrow(); rst_n = 1'b0; #1;
        nrow();
    endtask

    initial begin
        clr_in();
        //           rst ic  ia            dc dwr ds  da            dd   mrr mrd            mc  ma            busy irr ird           drr drd           perr
        // single fetch
        tbl[0]  = '{Y, N, Z32,          N, N, Z4, Z32,          Z32, N, Z32,          N, Z32,          N, N, Z32,          N, Z32,          N};
        tbl[1]  = '{N, Y, 32'hbfc00000, N, N, Z4, Z32,          Z32, N, Z32,          N, Z32,          N, N, Z32,          N, Z32,          N};
        tbl[2]  = '{N, N, Z32,          N, N, Z4, Z32,          Z32, N, Z32,          Y, 32'hbfc00000, Y, N, Z32,          N, Z32,          N};
        tbl[3]  = '{N, N, Z32,          N, N, Z4, Z32,          Z32, N, Z32,          N, 32'hbfc00000, Y, N, Z32,          N, Z32,          N};
        tbl[4]  = '{N, N, Z32,          N, N, Z4, Z32,          Z32, Y, 32'h3c1d0000, N, 32'hbfc00000, Y, Y, 32'h3c1d0000, N, Z32,          N};
        tbl[5]  = '{N, N, Z32,          N, N, Z4, Z32,          Z32, N, Z32,          N, 32'hbfc00000, N, N, Z32,          N, Z32,          N};
        // simultaneous after reset: data first, inst back-to-back
        tbl[6]  = '{Y, N, Z32,          N, N, Z4, Z32,          Z32, N, Z32,          N, Z32,          N, N, Z32,          N, Z32,          N};
        tbl[7]  = '{N, Y, 32'h00400000, Y, N, Z4, 32'h10000000, Z32, N, Z32,          N, Z32,          N, N, Z32,          N, Z32,          N};
        tbl[8]  = '{N, N, Z32,          N, N, Z4, Z32,          Z32, N, Z32,          Y, 32'h10000000, Y, N, Z32,          N, Z32,          N};
        tbl[9]  = '{N, N, Z32,          N, N, Z4, Z32,          Z32, Y, 32'h11111111, N, 32'h10000000, Y, N, Z32,          Y, 32'h11111111, N};
        tbl[10] = '{N, N, Z32,          N, N, Z4, Z32,          Z32, N, Z32,          Y, 32'h00400000, Y, N, Z32,          N, Z32,          N};
        tbl[11] = '{N, N, Z32,          N, N, Z4, Z32,          Z32, Y, 32'h22222222, N, 32'h00400000, Y, Y, 32'h22222222, N, Z32,          N};
        tbl[12] = '{N, N, Z32,          N, N, Z4, Z32,          Z32, N, Z32,          N, 32'h00400000, N, N, Z32,          N, Z32,          N};
        // stray completion while idle
        tbl[13] = '{Y, N, Z32,          N, N, Z4, Z32,          Z32, N, Z32,          N, Z32,          N, N, Z32,          N, Z32,          N};
        tbl[14] = '{N, N, Z32,          N, N, Z4, Z32,          Z32, Y, 32'hdeadbeef, N, Z32,          N, N, Z32,          N, Z32,          N};
        tbl[15] = '{N, N, Z32,          N, N, Z4, Z32,          Z32, N, Z32,          N, Z32,          N, N, Z32,          N, Z32,          Y};
        // second fetch pulse in flight, and one on its own completion cycle
        tbl[16] = '{Y, N, Z32,          N, N, Z4, Z32,          Z32, N, Z32,          N, Z32,          N, N, Z32,          N, Z32,          N};
        tbl[17] = '{N, Y, 32'h00000100, N, N, Z4, Z32,          Z32, N, Z32,          N, Z32,          N, N, Z32,          N, Z32,          N};
        tbl[18] = '{N, N, Z32,          N, N, Z4, Z32,          Z32, N, Z32,          Y, 32'h00000100, Y, N, Z32,          N, Z32,          N};
        tbl[19] = '{N, Y, 32'h00000200, N, N, Z4, Z32,          Z32, N, Z32,          N, 32'h00000100, Y, N, Z32,          N, Z32,          N};
        tbl[20] = '{N, N, Z32,          N, N, Z4, Z32,          Z32, N, Z32,          N, 32'h00000100, Y, N, Z32,          N, Z32,          Y};
        tbl[21] = '{N, Y, 32'h00000300, N, N, Z4, Z32,          Z32, Y, 32'h00000005, N, 32'h00000100, Y, Y, 32'h00000005, N, Z32,          Y};
        tbl[22] = '{N, N, Z32,          N, N, Z4, Z32,          Z32, N, Z32,          N, 32'h00000100, N, N, Z32,          N, Z32,          Y};

        for (int k = 0; k < 23; k++) begin
            @(negedge clk);
            row = k;
            rst_n                = !tbl[k].rst;
            bus.inst_call_begin  = tbl[k].ic;  bus.inst_addr  = tbl[k].ia;
            bus.data_call_begin  = tbl[k].dc;  bus.data_wr    = tbl[k].dwr;
            bus.data_wstrb       = tbl[k].ds;  bus.data_addr  = tbl[k].da;
            bus.data_wdata       = tbl[k].dd;
            bus.mem_return_ready = tbl[k].mrr; bus.mem_rdata  = tbl[k].mrd;
            #1;
            chk("mem_call_begin", 64'(bus.mem_call_begin), 64'(tbl[k].e_mc));
            chk("mem_addr", 64'(bus.mem_addr), 64'(tbl[k].e_ma));
            chk("busy", 64'(bus.busy), 64'(tbl[k].e_busy));
            chk("inst_return_ready", 64'(bus.inst_return_ready), 64'(tbl[k].e_irr));
            chk("inst_rdata", 64'(bus.inst_rdata), 64'(tbl[k].e_ird));
            chk("data_return_ready", 64'(bus.data_return_ready), 64'(tbl[k].e_drr));
            chk("data_rdata", 64'(bus.data_rdata), 64'(tbl[k].e_drd));
            chk("proto_err", 64'(bus.proto_err), 64'(tbl[k].e_perr));
        end

        // store payload held stable across a long cache wait
        row = 100;
        do_reset();
        bus.data_call_begin = 1'b1; bus.data_wr = 1'b1; bus.data_wstrb = 4'b0011;
        bus.data_addr = 32'h80001000; bus.data_wdata = 32'hdeadbeef;
        #1;
        nrow(); #1;
        chk("st_call", 64'(bus.mem_call_begin), 64'd1);
        chk("st_wr_strb", 64'({bus.mem_wr, bus.mem_wstrb}), 64'h13);
        chk("st_addr", 64'(bus.mem_addr), 64'h80001000);
        chk("st_wdata", 64'(bus.mem_wdata), 64'hdeadbeef);
        drr_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            nrow(); #1;
            chk("st_wait_call", 64'(bus.mem_call_begin), 64'd0);
            chk("st_wait_pld", {bus.mem_wr, bus.mem_wstrb, bus.mem_addr[26:0], bus.mem_wdata},
                {1'b1, 4'b0011, 27'h0001000, 32'hdeadbeef});
            chk("st_wait_irr", 64'(bus.inst_return_ready), 64'd0);
            if (bus.data_return_ready) drr_cnt++;
        end
        nrow(); bus.mem_return_ready = 1'b1; bus.mem_rdata = 32'h12345678; #1;
        if (bus.data_return_ready) drr_cnt++;
        chk("st_done_pld", {bus.mem_wr, bus.mem_wstrb, bus.mem_addr[26:0], bus.mem_wdata},
            {1'b1, 4'b0011, 27'h0001000, 32'hdeadbeef});
        chk("st_done_inst", 64'({bus.inst_return_ready, bus.inst_rdata}), 64'd0);
        nrow(); #1;
        if (bus.data_return_ready) drr_cnt++;
        chk("st_drr_pulses", 64'(drr_cnt), 64'd1);
        chk("st_busy_after", 64'(bus.busy), 64'd0);

        // six back-to-back transactions with both sides always re-requesting
        row = 200;
        do_reset();
        bus.inst_call_begin = 1'b1; bus.inst_addr = 32'h1001;
        bus.data_call_begin = 1'b1; bus.data_addr = 32'h2000;
        #1;
        for (int t = 0; t < 6; t++) begin
            nrow();
            if (t >= 1 && t <= 4) begin
                // previous owner is free again and asks for transaction t+1
                if (t % 2 == 1) begin
                    bus.data_call_begin = 1'b1; bus.data_addr = 32'h2000 + 32'(t + 1);
                end else begin
                    bus.inst_call_begin = 1'b1; bus.inst_addr = 32'h1000 + 32'(t + 1);
                end
            end
            #1;
            chk("alt_call", 64'(bus.mem_call_begin), 64'd1);
            chk("alt_addr", 64'(bus.mem_addr),
                (t % 2 == 0) ? 64'(32'h2000 + 32'(t)) : 64'(32'h1000 + 32'(t)));
            nrow(); bus.mem_return_ready = 1'b1; bus.mem_rdata = 32'ha0 + 32'(t); #1;
            chk("alt_ready", 64'({bus.inst_return_ready, bus.data_return_ready}),
                (t % 2 == 0) ? 64'b01 : 64'b10);
            chk("alt_rdata", 64'(bus.inst_rdata | bus.data_rdata), 64'(32'ha0 + 32'(t)));
        end
        nrow(); #1;
        chk("alt_busy_end", 64'(bus.busy), 64'd0);
        chk("alt_perr", 64'(bus.proto_err), 64'd0);

        // reset dropped while DATA_BUSY
        row = 300;
        do_reset();
        bus.data_call_begin = 1'b1; bus.data_addr = 32'h3000; #1;
        nrow(); #1;
        chk("rst_pre_busy", 64'({bus.mem_call_begin, bus.busy}), 64'b11);
        nrow(); rst_n = 1'b0; bus.mem_return_ready = 1'b1; bus.mem_rdata = 32'h55; #1;
        chk("rst_busy_call", 64'({bus.mem_call_begin, bus.busy, bus.proto_err}), 64'd0);
        chk("rst_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_data_ret", 64'({bus.data_return_ready, bus.data_rdata}), 64'd0);
        nrow(); bus.mem_return_ready = 1'b1; #1;
        chk("rst_stale_ret", 64'(bus.data_return_ready), 64'd0);
        nrow(); bus.inst_call_begin = 1'b1; bus.inst_addr = 32'h4000; #1;
        chk("rst_stale_perr", 64'({bus.proto_err, bus.busy}), 64'b10);
        nrow(); #1;
        chk("rst_refetch_call", 64'({bus.mem_call_begin, bus.busy}), 64'b11);
        chk("rst_refetch_addr", 64'(bus.mem_addr), 64'h4000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
